// File: rtl/fetch_unit_if.sv
// Fetch-to-ROM/decode/execute signal bundle for fetch_unit.
// master = fetch stage; slave = the ROM/decode/execute environment around it.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 18
);
    logic [ADDR_W-1:0]  o_addr;
    logic [INSTR_W-1:0] i_instr;
    logic               o_valid;
    logic               i_ready;
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_pc;
    logic               i_redirect;
    logic [ADDR_W-1:0]  i_redirect_addr;
    logic               o_done;

    modport master (
        output o_addr,
        output o_valid,
        output o_instr,
        output o_pc,
        output o_done,
        input  i_instr,
        input  i_ready,
        input  i_redirect,
        input  i_redirect_addr
    );

    modport slave (
        input  o_addr,
        input  o_valid,
        input  o_instr,
        input  o_pc,
        input  o_done,
        output i_instr,
        output i_ready,
        output i_redirect,
        output i_redirect_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the ROM word, and hands
// {instr, pc} to decode over valid/ready. Redirects flush the output slot.
module fetch_unit #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned INSTR_W    = 18,
    parameter int unsigned PROG_LEN   = 33,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned WRAP       = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_unit_if.master  bus
);

    // One extra bit so PROG_LEN == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   PROG_END  = PROG_LEN[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_ADDR);
    localparam bit                WRAP_EN   = (WRAP != 0);

    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [ADDR_W-1:0]  opc_q,   opc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    logic               in_range;
    logic               advance;
    logic [ADDR_W-1:0]  pc_next;

    always_comb begin
        in_range = ({1'b0, pc_q} < PROG_END);
        advance  = !valid_q || bus.i_ready;
        if (WRAP_EN && (pc_q == LAST_ADDR)) begin
            pc_next = RST_PC;
        end else begin
            pc_next = pc_q + ADDR_W'(1);
        end
    end

    // Redirect beats fetch; an out-of-range pc only drains the output slot.
    always_comb begin
        pc_d    = pc_q;
        opc_d   = opc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bus.i_redirect) begin
            pc_d    = bus.i_redirect_addr;
            valid_d = 1'b0;
        end else if (advance) begin
            if (in_range) begin
                instr_d = bus.i_instr;
                opc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_next;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q    <= RST_PC;
            opc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        bus.o_addr  = pc_q;
        bus.o_valid = valid_q;
        bus.o_instr = instr_q;
        bus.o_pc    = opc_q;
        bus.o_done  = !in_range && !valid_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a stop-at-end instance and a wrapping instance share
// stimulus; expectations come from an address-stream model of the program.
module tb_fetch_unit;

    localparam int unsigned PL = 33;

    logic clk = 1'b0;
    logic i_rst;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_next [2];
    bit          m_valid [2];

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(18)) bus0 ();
    fetch_unit_if #(.ADDR_W(16), .INSTR_W(18)) bus1 ();

    fetch_unit #(.ADDR_W(16), .INSTR_W(18), .PROG_LEN(33), .RESET_ADDR(0), .WRAP(0)) dut0 (
        .i_clk (clk),
        .i_rst (i_rst),
        .bus   (bus0)
    );

    fetch_unit #(.ADDR_W(16), .INSTR_W(18), .PROG_LEN(33), .RESET_ADDR(0), .WRAP(1)) dut1 (
        .i_clk (clk),
        .i_rst (i_rst),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] rom_word(input logic [15:0] a);
        if (a == 16'd0) return 18'b000001000000010000;
        if (a == 16'd3) return 18'b111000100000000000;
        if (a == 16'd5) return 18'b111001000000000000;
        if (a >= 16'd33) return 18'h2AAAA ^ {2'b00, a};
        return {a, 2'b01} ^ 18'h1C3C5;
    endfunction

    assign bus0.i_instr = rom_word(bus0.o_addr);
    assign bus1.i_instr = rom_word(bus1.o_addr);

    // Address decode should see after a given one.
    function automatic logic [15:0] succ(input bit wrap, input logic [15:0] a);
        if (wrap && a == 16'(PL - 1)) return 16'd0;
        return a + 16'd1;
    endfunction

    task automatic tick(input bit rst, input bit rdy, input bit redir, input logic [15:0] tgt);
        i_rst = rst;
        bus0.i_ready = rdy;  bus1.i_ready = rdy;
        bus0.i_redirect = redir;  bus1.i_redirect = redir;
        bus0.i_redirect_addr = tgt;  bus1.i_redirect_addr = tgt;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_next[k]  = 16'd0;
                m_valid[k] = 1'b0;
            end else if (redir) begin
                m_next[k]  = tgt;
                m_valid[k] = 1'b0;
            end else begin
                if (m_valid[k] && rdy) m_next[k] = succ(k == 1, m_next[k]);
                m_valid[k] = (m_next[k] < 16'(PL));
            end
        end
    endtask

    task automatic run_to(input logic [15:0] pc);
        int n = 0;
        while (!(bus0.o_valid === 1'b1 && bus0.o_pc === pc) && n < 100) begin
            tick(0, 1, 0, 16'd0);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL run_to: o_pc never reached %0d (last %0d)", pc, bus0.o_pc);
        end
    endtask

    task automatic test_reset;
        tick(1, 0, 0, 16'd0);
        tick(1, 0, 0, 16'd0);
        checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus0.o_valid); end
        checks++; if (bus0.o_instr !== 18'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus0.o_instr); end
        checks++; if (bus0.o_pc !== 16'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", bus0.o_pc); end
        checks++; if (bus0.o_addr !== 16'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus0.o_addr); end
        checks++; if (bus0.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus0.o_done); end
        checks++; if (bus1.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_wrap got=%b exp=0", bus1.o_valid); end
    endtask

    task automatic test_free_run;
        tick(1, 1, 0, 16'd0);
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", bus0.o_valid); end
        checks++; if (bus0.o_pc !== 16'd0) begin failures++; $display("FAIL first_pc got=%0d exp=0", bus0.o_pc); end
        checks++; if (bus0.o_instr !== 18'b000001000000010000) begin failures++; $display("FAIL first_instr got=%b exp=000001000000010000", bus0.o_instr); end
        for (int i = 1; i < 33; i++) begin
            tick(0, 1, 0, 16'd0);
            checks++;
            if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 16'(i)) begin
                failures++;
                $display("FAIL free_run_seq got valid=%b pc=%0d exp valid=1 pc=%0d", bus0.o_valid, bus0.o_pc, i);
            end
        end
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", bus0.o_valid); end
        checks++; if (bus0.o_done !== 1'b1) begin failures++; $display("FAIL drain_done got=%b exp=1", bus0.o_done); end
        checks++; if (bus0.o_addr !== 16'd33) begin failures++; $display("FAIL drain_addr got=%0d exp=33", bus0.o_addr); end
    endtask

    task automatic test_backpressure;
        tick(1, 1, 0, 16'd0);
        run_to(16'd5);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 16'd0);
            checks++;
            if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 16'd5 || bus0.o_instr !== 18'b111001000000000000 || bus0.o_addr !== 16'd6) begin
                failures++;
                $display("FAIL stall_hold got valid=%b pc=%0d instr=%b addr=%0d exp valid=1 pc=5 instr=111001000000000000 addr=6",
                         bus0.o_valid, bus0.o_pc, bus0.o_instr, bus0.o_addr);
            end
        end
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_pc !== 16'd6 || bus0.o_valid !== 1'b1) begin failures++; $display("FAIL stall_release got pc=%0d valid=%b exp pc=6 valid=1", bus0.o_pc, bus0.o_valid); end
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_pc !== 16'd7) begin failures++; $display("FAIL stall_next got pc=%0d exp=7", bus0.o_pc); end
    endtask

    task automatic test_redirect_flush;
        tick(1, 1, 0, 16'd0);
        run_to(16'd10);
        tick(0, 1, 1, 16'd3);
        checks++; if (bus0.o_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got valid=%b exp=0", bus0.o_valid); end
        tick(0, 1, 0, 16'd0);
        checks++;
        if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 16'd3 || bus0.o_instr !== 18'b111000100000000000) begin
            failures++;
            $display("FAIL redirect_target got valid=%b pc=%0d instr=%b exp valid=1 pc=3 instr=111000100000000000", bus0.o_valid, bus0.o_pc, bus0.o_instr);
        end
        for (int i = 4; i < 7; i++) begin
            tick(0, 1, 0, 16'd0);
            checks++; if (bus0.o_pc !== 16'(i)) begin failures++; $display("FAIL redirect_continue got pc=%0d exp=%0d", bus0.o_pc, i); end
        end
    endtask

    task automatic test_redirect_done;
        int n = 0;
        tick(1, 1, 0, 16'd0);
        while (bus0.o_done !== 1'b1 && n < 100) begin
            tick(0, 1, 0, 16'd0);
            n++;
        end
        checks++; if (bus0.o_done !== 1'b1) begin failures++; $display("FAIL reach_done got=%b exp=1", bus0.o_done); end
        tick(0, 0, 1, 16'd31);
        checks++; if (bus0.o_done !== 1'b0) begin failures++; $display("FAIL done_clear got=%b exp=0", bus0.o_done); end
        tick(0, 0, 0, 16'd0);
        tick(0, 0, 0, 16'd0);
        checks++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 16'd31) begin failures++; $display("FAIL done_restart_hold got valid=%b pc=%0d exp valid=1 pc=31", bus0.o_valid, bus0.o_pc); end
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 16'd32) begin failures++; $display("FAIL done_restart_last got valid=%b pc=%0d exp valid=1 pc=32", bus0.o_valid, bus0.o_pc); end
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_done !== 1'b1 || bus0.o_valid !== 1'b0) begin failures++; $display("FAIL done_again got done=%b valid=%b exp done=1 valid=0", bus0.o_done, bus0.o_valid); end
    endtask

    task automatic test_wrap;
        tick(1, 1, 0, 16'd0);
        for (int i = 0; i < 70; i++) begin
            tick(0, 1, 0, 16'd0);
            checks++;
            if (bus1.o_valid !== 1'b1 || bus1.o_pc !== 16'(i % 33) || bus1.o_done !== 1'b0) begin
                failures++;
                $display("FAIL wrap_seq got valid=%b pc=%0d done=%b exp valid=1 pc=%0d done=0", bus1.o_valid, bus1.o_pc, bus1.o_done, i % 33);
            end
        end
    endtask

    task automatic test_reset_mid_stall;
        tick(1, 1, 0, 16'd0);
        run_to(16'd7);
        tick(0, 0, 0, 16'd0);
        tick(1, 0, 1, 16'd20);
        checks++; if (bus0.o_valid !== 1'b0 || bus0.o_addr !== 16'd0) begin failures++; $display("FAIL rst_over_redirect got valid=%b addr=%0d exp valid=0 addr=0", bus0.o_valid, bus0.o_addr); end
        tick(0, 1, 0, 16'd0);
        checks++; if (bus0.o_valid !== 1'b1 || bus0.o_pc !== 16'd0) begin failures++; $display("FAIL rst_restart got valid=%b pc=%0d exp valid=1 pc=0", bus0.o_valid, bus0.o_pc); end
    endtask

    task automatic test_random;
        logic [15:0] exp_addr, o_addr, o_pc;
        logic [17:0] o_instr;
        logic        o_valid, o_done;
        tick(1, 1, 0, 16'd0);
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, 16'($urandom_range(0, 40)));
            for (int k = 0; k < 2; k++) begin
                o_valid = k ? bus1.o_valid : bus0.o_valid;
                o_done  = k ? bus1.o_done  : bus0.o_done;
                o_addr  = k ? bus1.o_addr  : bus0.o_addr;
                o_pc    = k ? bus1.o_pc    : bus0.o_pc;
                o_instr = k ? bus1.o_instr : bus0.o_instr;
                exp_addr = m_valid[k] ? succ(k == 1, m_next[k]) : m_next[k];
                checks++;
                if (o_valid !== m_valid[k] || o_addr !== exp_addr || o_done !== (m_next[k] >= 16'(PL))) begin
                    failures++;
                    $display("FAIL rand_ctrl dut%0d cyc=%0d got valid=%b addr=%0d done=%b exp valid=%b addr=%0d done=%b",
                             k, c, o_valid, o_addr, o_done, m_valid[k], exp_addr, m_next[k] >= 16'(PL));
                end
                if (m_valid[k]) begin
                    checks++;
                    if (o_pc !== m_next[k] || o_instr !== rom_word(m_next[k])) begin
                        failures++;
                        $display("FAIL rand_data dut%0d cyc=%0d got pc=%0d instr=%h exp pc=%0d instr=%h",
                                 k, c, o_pc, o_instr, m_next[k], rom_word(m_next[k]));
                    end
                end
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        bus0.i_ready = 1'b0;  bus1.i_ready = 1'b0;
        bus0.i_redirect = 1'b0;  bus1.i_redirect = 1'b0;
        bus0.i_redirect_addr = '0;  bus1.i_redirect_addr = '0;
        test_reset;
        test_free_run;
        test_backpressure;
        test_redirect_flush;
        test_redirect_done;
        test_wrap;
        test_reset_mid_stall;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the program ROM.
- Owns the program counter and drives the ROM address (o_addr). Captures the 18-bit instruction returned combinationally by the ROM into an output register.
- Presents {instruction, pc} to decode through a valid/ready handshake.
- Accepts PC redirects (jumps) from execute and reports program completion.

Parameters:
- ADDR_W, 16, PC/ROM address width.
- INSTR_W, 18, instruction width.
- PROG_LEN, 33, number of populated ROM words; addresses >= PROG_LEN are never fetched.
- RESET_ADDR, 0, PC value loaded on reset.
- WRAP, 0, 1 = PC returns to RESET_ADDR after PROG_LEN-1; 0 = stop fetching.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- o_addr  out  ADDR_W  ROM address; always equals the PC register.
- i_instr  in  INSTR_W  ROM data; combinational function of o_addr, valid in the same cycle.
- o_valid  out  1  output register holds an instruction not yet consumed.
- i_ready  in  1  decode accepts the output this cycle.
- o_instr  out  INSTR_W  fetched instruction.
- o_pc  out  ADDR_W  address that o_instr was fetched from.
- i_redirect  in  1  execute requests a jump; single-cycle pulse.
- i_redirect_addr  in  ADDR_W  jump target.
- o_done  out  1  program exhausted and output drained.

Behaviour:
- **Reset** (i_rst=1 at an edge):
  - pc <= RESET_ADDR; o_valid <= 0; o_instr <= 0; o_pc <= 0.
  - o_done is therefore 0 when RESET_ADDR < PROG_LEN.
  - Reset mid-stream discards any held instruction. Reset overrides redirect.
- **State:** pc register, plus output register {o_valid, o_instr, o_pc}.
- **Definitions:**
  - in_range = (pc < PROG_LEN).
  - advance = !o_valid || i_ready (output slot free or being freed).
  - Handshake transfer occurs when o_valid && i_ready.
- **Priority per edge** (highest first): reset, redirect, fetch, hold.
- **Redirect** (i_redirect=1):
  - pc <= i_redirect_addr; o_valid <= 0.
  - The held instruction is flushed even if i_ready=1 that cycle; decode treats a redirect cycle as a flush, not a transfer.
  - The instruction at the target appears at o_valid one edge later (redirect-to-valid latency 2 edges).
- **Fetch** (no redirect, advance=1, in_range=1):
  - o_instr <= i_instr; o_pc <= pc; o_valid <= 1.
  - pc <= pc+1, or RESET_ADDR if WRAP=1 and pc==PROG_LEN-1.
  - Result: back-to-back delivery, one instruction per cycle while i_ready=1.
- **Drain** (no redirect, advance=1, in_range=0):
  - o_valid <= 0 if a transfer occurred; pc unchanged; no further fetch.
- **Hold** (o_valid=1, i_ready=0, no redirect):
  - All state unchanged. o_instr/o_pc must stay stable while stalled.
- **Completion:** o_done = !in_range && !o_valid (combinational from registers).
  - Never asserted when WRAP=1 unless a redirect targets an address >= PROG_LEN.
  - A redirect to an in-range address clears o_done on the next edge.
- **Latency:** first o_valid=1 one edge after i_rst falls (fetch of RESET_ADDR).
- **Arithmetic:** pc+1 is modulo 2^ADDR_W. o_addr is never driven outside the pc register, so an out-of-range pc may appear on o_addr, but i_instr is ignored when !in_range.
- **Simultaneous events:**
  - Redirect with i_ready=0: the flush still happens.
  - Redirect to PROG_LEN-1: that one instruction is delivered, then drain.
  - Redirect during drain/done restarts fetch.

Test Plan:
- **Reset then free-run:** release i_rst, i_ready=1 constant. Required: o_valid rises 1 edge later with o_pc=0, o_instr=18'b000001000000010000; o_pc then increments 0..32 on consecutive cycles; o_valid falls after pc 32 is consumed; o_done=1 with o_addr=33.
- **Backpressure:** i_ready=0 for 3 cycles while o_pc=5. Required: o_pc=5, o_instr=18'b111001000000000000, o_valid=1 held stable; o_addr=6 constant. After i_ready=1, o_pc=6 on the next cycle with no skipped or duplicated address.
- **Redirect flush:** at o_pc=10 with i_ready=1, pulse i_redirect with target 3. Required: o_valid=0 on the next cycle; o_pc=3, o_instr=18'b111000100000000000 the cycle after; fetch continues 4, 5, ...
- **Redirect while stalled/done:** after o_done=1, redirect to 31 with i_ready=0. Required: o_done clears; o_valid=1 with o_pc=31 is held; after ready, 32 is delivered, then o_done=1 again.
- **Wrap mode:** WRAP=1, PROG_LEN=33, i_ready=1. Required: o_pc sequence ...31, 32, 0, 1 with no bubble; o_done stays 0.
- **Reset mid-stall:** o_valid=1, o_pc=7, i_ready=0, then assert i_rst together with i_redirect. Required: next edge o_valid=0, o_addr=0; fetch restarts at 0 with the redirect ignored.
